// File: rtl/led_blink_unit.sv
// Selectable-rate LED blinker: four free-running half-period counters each
// produce a 50 % square wave; the switches pick one, enable gates it onto the LED.
module led_blink_unit #(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int FREQ_0_HZ   = 100,
    parameter int FREQ_1_HZ   = 50,
    parameter int FREQ_2_HZ   = 10,
    parameter int FREQ_3_HZ   = 1,
    parameter bit SYNC_INPUTS = 1'b1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_switch_1,
    input  logic i_switch_2,
    output logic o_led_drive
);

    localparam int FREQ_HZ [4] = '{FREQ_0_HZ, FREQ_1_HZ, FREQ_2_HZ, FREQ_3_HZ};

    logic [2:0] raw_inputs;
    logic [2:0] clean_inputs;
    logic       enable_s;
    logic [1:0] select_s;
    logic [3:0] tog_vec;
    logic       led_reg;
    logic       led_next;

    assign raw_inputs = {i_enable, i_switch_1, i_switch_2};

    // Board switches are asynchronous; two flops settle them before use.
    generate
        if (SYNC_INPUTS) begin : g_sync
            logic [2:0] meta_reg;
            logic [2:0] sync_reg;
            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    meta_reg <= '0;
                    sync_reg <= '0;
                end else begin
                    meta_reg <= raw_inputs;
                    sync_reg <= meta_reg;
                end
            end
            assign clean_inputs = sync_reg;
        end else begin : g_nosync
            assign clean_inputs = raw_inputs;
        end
    endgenerate

    assign enable_s = clean_inputs[2];
    assign select_s = clean_inputs[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rate
            localparam int HALF_G = CLK_FREQ_HZ / (2 * FREQ_HZ[gi]);
            localparam int CW     = $clog2(HALF_G);
            localparam logic [CW-1:0] LAST = CW'(HALF_G - 1);

            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;
            logic          tog_reg;
            logic          tog_next;

            // Wrap and toggle share the same cycle, so a half period is exactly HALF_G clocks.
            always_comb begin
                cnt_next = cnt_reg + CW'(1);
                tog_next = tog_reg;
                if (cnt_reg == LAST) begin
                    cnt_next = '0;
                    tog_next = ~tog_reg;
                end
            end

            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    cnt_reg <= '0;
                    tog_reg <= 1'b0;
                end else begin
                    cnt_reg <= cnt_next;
                    tog_reg <= tog_next;
                end
            end

            assign tog_vec[gi] = tog_reg;
        end
    endgenerate

    always_comb begin
        led_next = enable_s & tog_vec[select_s];
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            led_reg <= 1'b0;
        end else begin
            led_reg <= led_next;
        end
    end

    assign o_led_drive = led_reg;

endmodule

// File: tb/tb_led_blink_unit.sv
// Bench for led_blink_unit: scaled-clock instance checked cycle by cycle against
// an arithmetic phase model, plus a default-parameter instance that must stay dark.
module tb_led_blink_unit;

    localparam int CF = 1000;
    localparam int RATE [4] = '{100, 50, 10, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic [1:0] sel = 2'b00;
    logic led;
    logic led_def;

    int checks = 0;
    int errors = 0;
    int e = 0;
    logic exp_led = 1'b0;
    int half [4];

    always #20 clk = ~clk;

    led_blink_unit #(
        .CLK_FREQ_HZ (CF),
        .SYNC_INPUTS (1'b0)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_enable    (en),
        .i_switch_1  (sel[1]),
        .i_switch_2  (sel[0]),
        .o_led_drive (led)
    );

    led_blink_unit dut_def (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_enable    (en),
        .i_switch_1  (sel[1]),
        .i_switch_2  (sel[0]),
        .o_led_drive (led_def)
    );

    // Phase of wave s after x non-reset edges: which half period we are in.
    function automatic logic tog_m(input int s, input int x);
        return logic'((x / half[s]) % 2);
    endfunction

    task automatic check(input string tag, input logic act, input logic exp_v);
        checks++;
        assert (act === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (edge %0d)", tag, act, exp_v, e);
        end
    endtask

    task automatic check_int(input string tag, input int act, input int exp_v);
        checks++;
        assert (act === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) begin
            e = 0;
            exp_led = 1'b0;
        end else begin
            exp_led = en & tog_m(int'(sel), e);
            e++;
        end
        #1;
        check("model", led, exp_led);
        check("defaults_dark", led_def, 1'b0);
    endtask

    task automatic measure_period(input int s);
        int n;
        int h;
        int l;
        logic prev;
        sel = 2'(s);
        en  = 1'b1;
        step();
        step();
        prev = led;
        n = 0;
        while (!(led === 1'b1 && prev === 1'b0) && n < 3 * half[s] + 4) begin
            prev = led;
            step();
            n++;
        end
        check_int($sformatf("rise_found_sel%0d", s), int'(led === 1'b1 && prev === 1'b0), 1);
        h = 1;
        step();
        while (led === 1'b1 && h < 2 * half[s] + 2) begin
            h++;
            step();
        end
        l = 1;
        step();
        while (led === 1'b0 && l < 2 * half[s] + 2) begin
            l++;
            step();
        end
        check_int($sformatf("high_len_sel%0d", s), h, half[s]);
        check_int($sformatf("low_len_sel%0d", s), l, half[s]);
        check_int($sformatf("period_sel%0d", s), h + l, 2 * half[s]);
    endtask

    initial begin
        int n;
        int hold;
        for (int i = 0; i < 4; i++) half[i] = CF / (2 * RATE[i]);

        // Reset held for 3 cycles with enable high
        rst = 1'b1;
        en  = 1'b1;
        sel = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_hold", led, 1'b0);
        end

        // First rise after release
        rst = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (led !== 1'b1 && n < 20);
        check_int("first_rise_edge", n, 6);

        // Reset mid-count at cycle 7
        step();
        rst = 1'b1;
        step();
        check("midcount_reset", led, 1'b0);
        rst = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (led !== 1'b1 && n < 20);
        check_int("rise_after_midreset", n, 6);

        for (int s = 0; s < 4; s++) measure_period(s);

        // Enable low for 37 cycles, then phase must match uninterrupted model
        sel = 2'b00;
        en  = 1'b0;
        for (int i = 0; i < 37; i++) begin
            step();
            check("enable_low", led, 1'b0);
        end
        en = 1'b1;
        for (int i = 0; i < 30; i++) step();

        // Switch 00 -> 11 while the 100 Hz wave is high
        sel = 2'b00;
        en  = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (led !== 1'b1 && n < 20);
        check_int("high_phase_found", int'(led === 1'b1), 1);
        sel = 2'b11;
        step();
        check("switch_to_tog3", led, tog_m(3, e - 1));
        for (int i = 0; i < 20; i++) begin
            step();
            check("tog0_probe", dut.tog_vec[0], tog_m(0, e));
        end

        // Randomized enable/select/reset traffic
        for (int i = 0; i < 300; i++) begin
            rst  = ($urandom_range(0, 59) == 0);
            en   = ($urandom_range(0, 4) != 0);
            sel  = 2'($urandom_range(0, 3));
            hold = $urandom_range(1, 8);
            for (int j = 0; j < hold; j++) begin
                step();
                if (rst) rst = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
